codec_reg_arbiter: RTL and testbench

Shares the single CODEC register port of `codec_unit_top` (`codec_rd_en`/`codec_wr_en`/`codec_reg_addr`/`codec_data_in`/`codec_data_out`, paced by `controller_busy`) between two requesters: requester 0 is the AXI software path and requester 1 is the hardware configuration path (output enable / sample-frequency updates). It serialises accesses with round-robin arbitration, sequences the one-shot register command and the I2C controller busy handshake, and returns read data and an error flag to the winning requester. It sits in the AXI clock domain between the register file and `codec_unit_top`.

---
 rtl/codec_reg_arbiter.sv | 116 +++++++++++
 tb/tb_codec_reg_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_reg_arbiter.sv
// codec_reg_arbiter: round-robin sharing of the CODEC register port between two requesters.
// Define CODEC_ARB_TIMEOUT_EN to compile in the completion timeout and the reqN_err path.
module codec_reg_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              axi_clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              codec_rd_en,
  output logic              codec_wr_en,
  output logic [ADDR_W-1:0] codec_reg_addr,
  output logic [DATA_W-1:0] codec_data_in,
  input  logic [DATA_W-1:0] codec_data_out,
  input  logic              controller_busy,
  output logic              arb_busy,
  output logic              last_grant
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_BUSY = 3'd2, WAIT_DONE = 3'd3, RESP = 3'd4;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit timeout counter");
  end
  logic [2:0] state_q, state_d;
  logic gnt, ready, accept, cap, tmo, fin;
  logic gnt_q, we_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  // tie goes to whoever did not win last time
  assign gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign ready = (state_q == IDLE) & ~controller_busy & ~reset;
  assign accept = ready & (gnt ? req1_valid : req0_valid);
  assign cap = (state_q == WAIT_DONE) & ~controller_busy;
  assign fin = cap | tmo;
`ifdef CODEC_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic err_q;
  // a completing handshake beats a timeout landing in the same cycle
  assign tmo = ~cap & ((state_q == WAIT_BUSY) | (state_q == WAIT_DONE)) &
               (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ISSUE) ? '0 :
               ((state_q == WAIT_BUSY) | (state_q == WAIT_DONE)) ? cnt_q + 16'd1 : cnt_q;
      if (fin) err_q <= tmo;
    end
  end
  assign req0_err = req0_done & err_q;
  assign req1_err = req1_done & err_q;
`else
  assign tmo = 1'b0;
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif
  always_comb begin
    state_d = (state_q == IDLE)      ? (accept ? ISSUE : IDLE) :
              (state_q == ISSUE)     ? WAIT_BUSY :
              (state_q == RESP)      ? IDLE :
              fin                    ? RESP :
              (state_q == WAIT_BUSY) ? (controller_busy ? WAIT_DONE : WAIT_BUSY) :
              (state_q == WAIT_DONE) ? WAIT_DONE : IDLE;
  end
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      we_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q <= gnt;
        we_q <= gnt ? req1_we : req0_we;
        addr_q <= gnt ? req1_addr : req0_addr;
        wdata_q <= gnt ? req1_wdata : req0_wdata;
      end
      if (fin & ~we_q & ~gnt_q) rdata0_q <= tmo ? '0 : codec_data_out;
      if (fin & ~we_q & gnt_q) rdata1_q <= tmo ? '0 : codec_data_out;
      if (state_q == RESP) last_q <= gnt_q;
    end
  end
  assign req0_ready = ready & ~gnt;
  assign req1_ready = ready & gnt;
  assign codec_wr_en = (state_q == ISSUE) & we_q & ~reset;
  assign codec_rd_en = (state_q == ISSUE) & ~we_q & ~reset;
  assign req0_done = (state_q == RESP) & ~gnt_q & ~reset;
  assign req1_done = (state_q == RESP) & gnt_q & ~reset;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign codec_reg_addr = addr_q;
  assign codec_data_in = wdata_q;
  assign arb_busy = state_q != IDLE;
  assign last_grant = last_q;
endmodule

// File: tb/tb_codec_reg_arbiter.sv
// tb_codec_reg_arbiter: vector table, directed corner cases and random traffic
// checked against a transaction-level model of the arbiter and a CODEC register device.
module tb_codec_reg_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bit rv[2];
  logic rwe[2];
  logic [6:0] raddr[2];
  logic [7:0] rwd[2];
  logic busy = 1'b0;
  logic [7:0] dout = 8'h00;
  logic req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata, codec_data_in;
  logic [6:0] codec_reg_addr;
  logic codec_rd_en, codec_wr_en, arb_busy, last_grant;
  codec_reg_arbiter #(.ADDR_W(7), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk(clk), .reset(rst),
    .req0_valid(rv[0]), .req0_we(rwe[0]), .req0_addr(raddr[0]), .req0_wdata(rwd[0]),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(rv[1]), .req1_we(rwe[1]), .req1_addr(raddr[1]), .req1_wdata(rwd[1]),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en), .codec_reg_addr(codec_reg_addr),
    .codec_data_in(codec_data_in), .codec_data_out(dout), .controller_busy(busy),
    .arb_busy(arb_busy), .last_grant(last_grant)
  );
  typedef struct {
    bit g;
    bit we;
    logic [6:0] addr;
    logic [7:0] wd;
    int d1;
    int d2;
    int lat;
    logic [7:0] rd;
    bit err;
  } vec_t;
  vec_t vt[5];
  int checks = 0, errors = 0, n = 0;
  // queued stimulus, applied just after the next rising edge
  bit q_rst = 1'b1, q_force = 1'b0, auto_req = 1'b0, refill = 1'b0;
  bit q_v[2];
  logic q_we[2];
  logic [6:0] q_addr[2];
  logic [7:0] q_wd[2];
  int d1 = 0, d2 = 1;
  // model of the transaction in flight and of the CODEC register file
  bit act = 1'b0, t_g, t_we, t_to, last_exp = 1'b1;
  int c_acc, cmd_at, rise_at, fall_at, done_at;
  logic [7:0] t_rd, m_wd = 8'h00;
  logic [6:0] m_addr = 7'h00;
  logic [7:0] mem[128];
  logic [7:0] mrd[2];
  bit acc_flag[2];
  int obs_acc_n, obs_done_n, ngr;
  bit obs_dg, obs_err;
  logic [7:0] obs_rd;
  int gseq[4];
  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, n, act_v, exp_v);
    end
  endtask
  task automatic drive();
    n++;
    rst = q_rst;
    for (int i = 0; i < 2; i++) begin
      if (auto_req) begin
        if (acc_flag[i] || !rv[i]) begin
          rv[i] = ($urandom % 2) == 1;
          rwe[i] = ($urandom % 2) == 1;
          raddr[i] = 7'($urandom);
          rwd[i] = 8'($urandom);
        end else if ($urandom % 16 == 0) rv[i] = 1'b0;
      end else begin
        if (acc_flag[i] && refill) begin
          q_we[i] = ($urandom % 2) == 1;
          q_addr[i] = 7'($urandom);
          q_wd[i] = 8'($urandom);
        end else if (acc_flag[i]) q_v[i] = 1'b0;
        rv[i] = q_v[i];
        rwe[i] = q_we[i];
        raddr[i] = q_addr[i];
        rwd[i] = q_wd[i];
      end
    end
    busy = q_force || (act && !t_to && n >= rise_at && n < fall_at);
    dout = (act && !t_we && !t_to && n >= rise_at && n <= fall_at) ? t_rd : 8'($urandom);
  endtask
  task automatic check();
    bit inf, g, e0, e1, dn;
    if (req0_ready && rv[0]) begin
      obs_acc_n = n;
      if (ngr < 4) gseq[ngr++] = 0;
    end
    if (req1_ready && rv[1]) begin
      obs_acc_n = n;
      if (ngr < 4) gseq[ngr++] = 1;
    end
    if (req0_done || req1_done) begin
      obs_done_n = n;
      obs_dg = req1_done;
      obs_rd = req1_done ? req1_rdata : req0_rdata;
      obs_err = req1_done ? req1_err : req0_err;
    end
    chk("cmd_exclusive", 32'(codec_rd_en & codec_wr_en), 32'd0);
    acc_flag[0] = 1'b0;
    acc_flag[1] = 1'b0;
    if (rst) begin
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_cmd", 32'({codec_rd_en, codec_wr_en}), 32'd0);
      chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
      act = 1'b0;
      last_exp = 1'b1;
      mrd[0] = 8'h00;
      mrd[1] = 8'h00;
      m_addr = 7'h00;
      m_wd = 8'h00;
      return;
    end
    inf = act && n > c_acc && n <= done_at;
    dn = inf && n == done_at;
    g = (rv[0] && rv[1]) ? !last_exp : rv[1];
    e0 = !inf && !busy && !g;
    e1 = !inf && !busy && g;
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    chk("arb_busy", 32'(arb_busy), 32'(inf));
    chk("last_grant", 32'(last_grant), 32'(last_exp));
    chk("reg_addr", 32'(codec_reg_addr), 32'(m_addr));
    chk("data_in", 32'(codec_data_in), 32'(m_wd));
    chk("wr_en", 32'(codec_wr_en), 32'(inf && n == cmd_at && t_we));
    chk("rd_en", 32'(codec_rd_en), 32'(inf && n == cmd_at && !t_we));
    if (dn && !t_we) mrd[t_g] = t_to ? 8'h00 : t_rd;
    chk("done0", 32'(req0_done), 32'(dn && !t_g));
    chk("done1", 32'(req1_done), 32'(dn && t_g));
    chk("err0", 32'(req0_err), 32'(dn && !t_g && t_to));
    chk("err1", 32'(req1_err), 32'(dn && t_g && t_to));
    chk("rdata0", 32'(req0_rdata), 32'(mrd[0]));
    chk("rdata1", 32'(req1_rdata), 32'(mrd[1]));
    if (dn) begin
      last_exp = t_g;
      act = 1'b0;
    end
    if ((e0 && rv[0]) || (e1 && rv[1])) begin
      t_g = g;
      t_we = rwe[g];
      t_rd = mem[raddr[g]];
      if (t_we) mem[raddr[g]] = rwd[g];
      m_addr = raddr[g];
      m_wd = rwd[g];
      c_acc = n;
      cmd_at = n + 1;
      rise_at = n + 2 + d1;
      fall_at = rise_at + d2;
      t_to = d2 == 0;
      done_at = t_to ? n + 2 + TO : fall_at + 1;
      act = 1'b1;
      acc_flag[g] = 1'b1;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check();
  endtask
  task automatic wait_done(input string nm);
    obs_done_n = -1;
    for (int k = 0; k < 100 && obs_done_n < 0; k++) step();
    chk(nm, 32'(obs_done_n >= 0), 32'd1);
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && act; k++) step();
    chk("drain_idle", 32'(act), 32'd0);
  endtask
  task automatic request(input bit g, input bit we, input logic [6:0] a, input logic [7:0] w);
    q_v[g] = 1'b1;
    q_we[g] = we;
    q_addr[g] = a;
    q_wd[g] = w;
  endtask
  initial begin
    vt[0] = '{1'b0, 1'b1, 7'h07, 8'h0A, 0, 1, 4, 8'h00, 1'b0};
    vt[1] = '{1'b1, 1'b0, 7'h09, 8'h00, 0, 1, 4, 8'h5C, 1'b0};
    vt[2] = '{1'b0, 1'b0, 7'h07, 8'h00, 2, 3, 8, 8'h0A, 1'b0};
    vt[3] = '{1'b1, 1'b1, 7'h09, 8'h33, 1, 2, 6, 8'h5C, 1'b0};
    vt[4] = '{1'b1, 1'b0, 7'h09, 8'h00, 0, 2, 5, 8'h33, 1'b0};
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[9] = 8'h5C;
    for (int i = 0; i < 2; i++) begin
      q_v[i] = 1'b0;
      q_we[i] = 1'b0;
      q_addr[i] = 7'h00;
      q_wd[i] = 8'h00;
      rv[i] = 1'b0;
      rwe[i] = 1'b0;
      raddr[i] = 7'h00;
      rwd[i] = 8'h00;
      mrd[i] = 8'h00;
      acc_flag[i] = 1'b0;
    end
    step();
    step();
    q_rst = 1'b0;
    step();
    chk("reset_last_grant", 32'(last_grant), 32'd1);
    chk("reset_arb_busy", 32'(arb_busy), 32'd0);
    chk("reset_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
    chk("reset_addr_data", 32'({codec_reg_addr, codec_data_in}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      d1 = vt[i].d1;
      d2 = vt[i].d2;
      request(vt[i].g, vt[i].we, vt[i].addr, vt[i].wd);
      obs_acc_n = -1;
      wait_done("vec_done_seen");
      chk("vec_requester", 32'(obs_dg), 32'(vt[i].g));
      chk("vec_latency", 32'(obs_done_n - obs_acc_n), 32'(vt[i].lat));
      chk("vec_rdata", 32'(obs_rd), 32'(vt[i].rd));
      chk("vec_err", 32'(obs_err), 32'(vt[i].err));
    end
    d1 = 0;
    d2 = 1;
    ngr = 0;
    refill = 1'b1;
    request(1'b0, 1'b1, 7'h10, 8'h01);
    request(1'b1, 1'b0, 7'h11, 8'h02);
    for (int k = 0; k < 200 && ngr < 4; k++) step();
    q_v[0] = 1'b0;
    q_v[1] = 1'b0;
    refill = 1'b0;
    chk("cont_grant_count", 32'(ngr), 32'd4);
    for (int i = 0; i < 4; i++) chk("cont_grant", 32'(gseq[i]), 32'(i % 2));
    drain();
    step();
    chk("cont_last_grant", 32'(last_grant), 32'd1);
    q_force = 1'b1;
    request(1'b0, 1'b0, 7'h03, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("busy_ready0", 32'(req0_ready), 32'd0);
    end
    q_force = 1'b0;
    obs_acc_n = -1;
    step();
    chk("busy_accept_cycle", 32'(obs_acc_n), 32'(n));
    wait_done("busy_done_seen");
`ifdef CODEC_ARB_TIMEOUT_EN
    d2 = 0;
    mem[5] = 8'hA5;
    request(1'b0, 1'b0, 7'h05, 8'h00);
    obs_acc_n = -1;
    wait_done("tmo_done_seen");
    chk("tmo_latency", 32'(obs_done_n - obs_acc_n), 32'(TO + 2));
    chk("tmo_err", 32'(obs_err), 32'd1);
    chk("tmo_rdata", 32'(obs_rd), 32'd0);
    d2 = 1;
`endif
    d1 = 0;
    d2 = 8;
    request(1'b1, 1'b1, 7'h02, 8'hC3);
    for (int k = 0; k < 40 && !(act && n >= rise_at + 1); k++) step();
    chk("rst_mid_reached", 32'(act && n >= rise_at + 1), 32'd1);
    q_rst = 1'b1;
    step();
    q_rst = 1'b0;
    step();
    chk("rst_mid_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_mid_last_grant", 32'(last_grant), 32'd1);
    chk("rst_mid_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
    chk("rst_mid_addr_data", 32'({codec_reg_addr, codec_data_in}), 32'd0);
    d1 = 1;
    d2 = 1;
    request(1'b0, 1'b0, 7'h02, 8'h00);
    wait_done("rst_after_done_seen");
    chk("rst_after_rdata", 32'(obs_rd), 32'hC3);
    chk("rst_after_err", 32'(obs_err), 32'd0);
    auto_req = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      d1 = $urandom % 3;
      d2 = 1 + $urandom % 3;
`ifdef CODEC_ARB_TIMEOUT_EN
      if ($urandom % 32 == 0) d2 = 0;
`endif
      q_force = !act && ($urandom % 8 == 0);
      step();
    end
    auto_req = 1'b0;
    q_force = 1'b0;
    q_v[0] = 1'b0;
    q_v[1] = 1'b0;
    step();
    drain();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
